// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central stall / flush / redirect controller for a five-stage pipeline.
// Arbitrates data-bus stalls, taken jumps, load-use hazards and fetch stalls.
// Jumps that resolve while the bus is busy are parked and replayed afterwards.
// A bus watchdog sets a sticky timeout flag, and two free-running counters
// record how many cycles were spent stalling and redirecting.
module pipe_ctrl #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_in,
  input  logic        reset_n_in,
  input  logic        if_stallreq_in,
  input  logic        id_stallreq_in,
  input  logic        mem_stallreq_in,
  input  logic        exe_jump_in,
  input  logic [31:0] exe_jump_addr_in,
  output logic [4:0]  stall_out,
  output logic [1:0]  flush_out,
  output logic        jump_out,
  output logic [31:0] jump_addr_out,
  output logic        bus_timeout_out,
  output logic [31:0] stall_cnt_out,
  output logic [31:0] jump_cnt_out
);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MEM_WAIT  = 2'd1,
    JUMP_PEND = 2'd2,
    FLUSH2    = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

  state_t      state_reg, state_next;
  logic        pend_reg, pend_next;
  logic [31:0] pend_addr_reg, pend_addr_next;
  logic        owe_reg, owe_next;
  logic [7:0]  wait_cnt_reg, wait_cnt_next;
  logic        timeout_reg, timeout_next;
  logic [31:0] stall_cnt_reg, stall_cnt_next;
  logic [31:0] jump_cnt_reg, jump_cnt_next;

  logic mem_act;
  logic issue_pend;
  logic issue_live;
  logic flush_owed;

  // Qualify requests once so output decode and next-state logic agree.
  // A jump arriving in JUMP_PEND is not issued: the parked target goes first.
  always_comb begin
    mem_act    = mem_stallreq_in & ~timeout_reg;
    issue_pend = (state_reg == JUMP_PEND);
    issue_live = exe_jump_in & (state_reg != JUMP_PEND);
    flush_owed = (state_reg == FLUSH2) | owe_reg;
  end

  // Output decode in priority order. All outputs are forced quiet while reset is held.
  always_comb begin
    stall_out     = 5'b00000;
    flush_out     = 2'b00;
    jump_out      = 1'b0;
    jump_addr_out = 32'd0;
    if (!reset_n_in) begin
      stall_out = 5'b00000;
    end else if (mem_act) begin
      stall_out = 5'b01111;
    end else if (issue_pend) begin
      jump_out      = 1'b1;
      jump_addr_out = pend_addr_reg;
      flush_out     = 2'b11;
    end else if (issue_live) begin
      jump_out      = 1'b1;
      jump_addr_out = exe_jump_addr_in;
      flush_out     = 2'b11;
    end else if (flush_owed) begin
      // Second bubble cycle of a redirect: ignore fetch and decode stall requests.
      flush_out = 2'b11;
    end else if (id_stallreq_in) begin
      stall_out = 5'b00011;
      flush_out = 2'b10;
    end else if (if_stallreq_in) begin
      stall_out = 5'b00001;
      flush_out = 2'b01;
    end
  end

  // Next-state logic and bookkeeping: pending jump, owed flush, bus watchdog, counters.
  always_comb begin
    state_next     = state_reg;
    pend_next      = pend_reg;
    pend_addr_next = pend_addr_reg;
    owe_next       = owe_reg;
    wait_cnt_next  = wait_cnt_reg;
    timeout_next   = timeout_reg;
    if (mem_act) begin
      state_next    = MEM_WAIT;
      wait_cnt_next = wait_cnt_reg + 8'd1;
      if ((wait_cnt_reg + 8'd1) == TIMEOUT_LIM) begin
        timeout_next = 1'b1;
      end
      // Park the newest jump target. A later pulse overwrites an earlier one.
      if (exe_jump_in) begin
        pend_next      = 1'b1;
        pend_addr_next = exe_jump_addr_in;
      end
      // A stall that interrupts the second bubble cycle still owes that bubble.
      if (state_reg == FLUSH2) begin
        owe_next = 1'b1;
      end
    end else begin
      wait_cnt_next = 8'd0;
      // An owed bubble is served this cycle, either on its own or by a redirect.
      owe_next      = 1'b0;
      if (issue_pend || issue_live) begin
        state_next = FLUSH2;
        pend_next  = 1'b0;
      end else if ((state_reg == MEM_WAIT) && pend_reg) begin
        state_next = JUMP_PEND;
      end else begin
        state_next = RUN;
      end
    end
    stall_cnt_next = stall_cnt_reg + {31'd0, |stall_out};
    jump_cnt_next  = jump_cnt_reg + {31'd0, jump_out};
  end

  // State and counter registers with asynchronous active-low clear.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_reg     <= RUN;
      pend_reg      <= 1'b0;
      pend_addr_reg <= 32'd0;
      owe_reg       <= 1'b0;
      wait_cnt_reg  <= 8'd0;
      timeout_reg   <= 1'b0;
      stall_cnt_reg <= 32'd0;
      jump_cnt_reg  <= 32'd0;
    end else begin
      state_reg     <= state_next;
      pend_reg      <= pend_next;
      pend_addr_reg <= pend_addr_next;
      owe_reg       <= owe_next;
      wait_cnt_reg  <= wait_cnt_next;
      timeout_reg   <= timeout_next;
      stall_cnt_reg <= stall_cnt_next;
      jump_cnt_reg  <= jump_cnt_next;
    end
  end

  assign bus_timeout_out = timeout_reg;
  assign stall_cnt_out   = stall_cnt_reg;
  assign jump_cnt_out    = jump_cnt_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scenario tasks plus a randomized run for pipe_ctrl. Every cycle
// is compared against a history-based reference model. A second instance with a
// short watchdog covers the timeout path.
module tb_pipe_ctrl;

  localparam int TO_MAIN  = 255;
  localparam int TO_SHORT = 4;

  logic        clk_in = 1'b0;
  logic        reset_n_in;
  logic        if_stallreq_in, id_stallreq_in, mem_stallreq_in, exe_jump_in;
  logic [31:0] exe_jump_addr_in;

  logic [4:0]  stall_out;
  logic [1:0]  flush_out;
  logic        jump_out;
  logic [31:0] jump_addr_out;
  logic        bus_timeout_out;
  logic [31:0] stall_cnt_out, jump_cnt_out;

  logic [4:0]  to_stall;
  logic [1:0]  to_flush;
  logic        to_jump;
  logic [31:0] to_addr;
  logic        to_timeout;
  logic [31:0] to_stall_cnt, to_jump_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk_in = ~clk_in;

  pipe_ctrl #(.TIMEOUT_CYCLES(TO_MAIN)) dut (
    .clk_in(clk_in), .reset_n_in(reset_n_in),
    .if_stallreq_in(if_stallreq_in), .id_stallreq_in(id_stallreq_in),
    .mem_stallreq_in(mem_stallreq_in), .exe_jump_in(exe_jump_in),
    .exe_jump_addr_in(exe_jump_addr_in),
    .stall_out(stall_out), .flush_out(flush_out), .jump_out(jump_out),
    .jump_addr_out(jump_addr_out), .bus_timeout_out(bus_timeout_out),
    .stall_cnt_out(stall_cnt_out), .jump_cnt_out(jump_cnt_out)
  );

  pipe_ctrl #(.TIMEOUT_CYCLES(TO_SHORT)) dut_to (
    .clk_in(clk_in), .reset_n_in(reset_n_in),
    .if_stallreq_in(if_stallreq_in), .id_stallreq_in(id_stallreq_in),
    .mem_stallreq_in(mem_stallreq_in), .exe_jump_in(exe_jump_in),
    .exe_jump_addr_in(exe_jump_addr_in),
    .stall_out(to_stall), .flush_out(to_flush), .jump_out(to_jump),
    .jump_addr_out(to_addr), .bus_timeout_out(to_timeout),
    .stall_cnt_out(to_stall_cnt), .jump_cnt_out(to_jump_cnt)
  );

  // ---------------- reference model (history flags, not FSM states) ----------
  logic        m_timeout;
  logic        m_pend;
  logic [31:0] m_pend_addr;
  logic        m_owed;          // a bubble cycle was cut short by a bus stall
  logic        m_prev_mem;      // previous cycle was an active bus stall
  logic        m_prev_issue;    // previous cycle issued a redirect
  logic        m_replay;        // previous cycle ended a stall with a parked jump
  int          m_waits;
  logic [31:0] m_stall_cnt, m_jump_cnt;

  logic [4:0]  e_stall;
  logic [1:0]  e_flush;
  logic        e_jump;
  logic [31:0] e_addr;

  task automatic model_reset();
    m_timeout = 0; m_pend = 0; m_pend_addr = 0; m_owed = 0;
    m_prev_mem = 0; m_prev_issue = 0; m_replay = 0; m_waits = 0;
    m_stall_cnt = 0; m_jump_cnt = 0;
  endtask

  task automatic model_eval();
    logic mem;
    mem = mem_stallreq_in && !m_timeout;
    e_stall = 0; e_flush = 0; e_jump = 0; e_addr = 0;
    if (!reset_n_in) begin
      e_stall = 0;
    end else if (mem) begin
      e_stall = 5'b01111;
    end else if (m_replay) begin
      e_jump = 1; e_addr = m_pend_addr; e_flush = 2'b11;
    end else if (exe_jump_in) begin
      e_jump = 1; e_addr = exe_jump_addr_in; e_flush = 2'b11;
    end else if (m_prev_issue || m_owed) begin
      e_flush = 2'b11;
    end else if (id_stallreq_in) begin
      e_stall = 5'b00011; e_flush = 2'b10;
    end else if (if_stallreq_in) begin
      e_stall = 5'b00001; e_flush = 2'b01;
    end
  endtask

  task automatic model_commit();
    logic mem;
    if (!reset_n_in) begin
      model_reset();
    end else begin
      if (e_stall != 0) m_stall_cnt = m_stall_cnt + 1;
      if (e_jump) m_jump_cnt = m_jump_cnt + 1;
      mem = mem_stallreq_in && !m_timeout;
      if (mem) begin
        m_waits = m_waits + 1;
        if (m_waits == TO_MAIN) m_timeout = 1;
        if (exe_jump_in) begin m_pend = 1; m_pend_addr = exe_jump_addr_in; end
        if (m_prev_issue) m_owed = 1;
        m_replay = 0; m_prev_issue = 0; m_prev_mem = 1;
      end else begin
        m_waits = 0;
        m_owed = 0;
        if (e_jump) m_pend = 0;
        m_replay = !e_jump && m_prev_mem && m_pend;
        m_prev_issue = e_jump;
        m_prev_mem = 0;
      end
    end
  endtask

  // ---------------- stimulus plumbing ----------------------------------------
  task automatic apply(input logic f, input logic d, input logic m, input logic j,
                       input logic [31:0] a);
    if_stallreq_in = f; id_stallreq_in = d; mem_stallreq_in = m;
    exe_jump_in = j; exe_jump_addr_in = a;
  endtask

  task automatic pre_cycle();
    model_eval();
    @(negedge clk_in);
    $display("t=%0t rst_n=%b if=%b id=%b mem=%b jmp=%b a=%h | stall=%b flush=%b jump=%b ja=%h to=%b sc=%0d jc=%0d",
             $time, reset_n_in, if_stallreq_in, id_stallreq_in, mem_stallreq_in, exe_jump_in,
             exe_jump_addr_in, stall_out, flush_out, jump_out, jump_addr_out, bus_timeout_out,
             stall_cnt_out, jump_cnt_out);
  endtask

  task automatic post_cycle();
    @(posedge clk_in);
    model_commit();
    #1;
  endtask

  task automatic do_reset();
    apply(0, 0, 0, 0, 32'd0);
    reset_n_in = 0;
    model_reset();
    @(posedge clk_in);
    #1;
    reset_n_in = 1;
  endtask

  // ---------------- scenarios ------------------------------------------------
  task automatic test_reset();
    reset_n_in = 0;
    model_reset();
    apply(1, 1, 1, 1, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      pre_cycle();
      checks++;
      if ({stall_out, flush_out, jump_out, jump_addr_out} !== 40'd0) begin
        errors++;
        $display("FAIL reset_outputs: got stall=%b flush=%b jump=%b addr=%h, expected all zero",
                 stall_out, flush_out, jump_out, jump_addr_out);
      end
      checks++;
      if ({bus_timeout_out, stall_cnt_out, jump_cnt_out} !== 65'd0) begin
        errors++;
        $display("FAIL reset_state: got to=%b sc=%0d jc=%0d, expected zeros",
                 bus_timeout_out, stall_cnt_out, jump_cnt_out);
      end
      post_cycle();
    end
    reset_n_in = 1;
    apply(0, 0, 0, 0, 32'd0);
    for (int i = 0; i < 2; i++) begin
      pre_cycle();
      checks++;
      if ({stall_out, flush_out, jump_out, jump_addr_out, stall_cnt_out, jump_cnt_out} !== 104'd0) begin
        errors++;
        $display("FAIL reset_release_idle: got stall=%b flush=%b jump=%b sc=%0d jc=%0d, expected zeros",
                 stall_out, flush_out, jump_out, stall_cnt_out, jump_cnt_out);
      end
      post_cycle();
    end
  endtask

  task automatic test_load_use();
    for (int i = 0; i < 4; i++) begin
      case (i)
        0: apply(0, 1, 0, 0, 32'd0);
        2: apply(1, 0, 0, 0, 32'd0);
        default: apply(0, 0, 0, 0, 32'd0);
      endcase
      pre_cycle();
      checks++;
      if ({stall_out, flush_out, jump_out, jump_addr_out} !== {e_stall, e_flush, e_jump, e_addr}) begin
        errors++;
        $display("FAIL load_use_outputs cyc%0d: got %b/%b/%b/%h expected %b/%b/%b/%h", i,
                 stall_out, flush_out, jump_out, jump_addr_out, e_stall, e_flush, e_jump, e_addr);
      end
      checks++;
      if ({bus_timeout_out, stall_cnt_out, jump_cnt_out} !== {m_timeout, m_stall_cnt, m_jump_cnt}) begin
        errors++;
        $display("FAIL load_use_counters cyc%0d: got sc=%0d jc=%0d expected sc=%0d jc=%0d", i,
                 stall_cnt_out, jump_cnt_out, m_stall_cnt, m_jump_cnt);
      end
      if (i == 0) begin
        checks++;
        if (stall_out !== 5'b00011 || flush_out !== 2'b10) begin
          errors++;
          $display("FAIL load_use_pattern: got stall=%b flush=%b expected 00011/10", stall_out, flush_out);
        end
      end
      if (i == 1) begin
        checks++;
        if (stall_cnt_out !== 32'd1) begin
          errors++;
          $display("FAIL load_use_count: got %0d expected 1", stall_cnt_out);
        end
      end
      if (i == 2) begin
        checks++;
        if (stall_out !== 5'b00001 || flush_out !== 2'b01) begin
          errors++;
          $display("FAIL fetch_stall_pattern: got stall=%b flush=%b expected 00001/01", stall_out, flush_out);
        end
      end
      post_cycle();
    end
  endtask

  task automatic test_jump();
    logic [31:0] jc0;
    jc0 = m_jump_cnt;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) apply(0, 0, 0, 1, 32'h0000_0100);
      else if (i == 1) apply(1, 1, 0, 0, 32'd0);  // hazards must be ignored in the bubble cycle
      else apply(0, 0, 0, 0, 32'd0);
      pre_cycle();
      checks++;
      if ({stall_out, flush_out, jump_out, jump_addr_out} !== {e_stall, e_flush, e_jump, e_addr}) begin
        errors++;
        $display("FAIL jump_outputs cyc%0d: got %b/%b/%b/%h expected %b/%b/%b/%h", i,
                 stall_out, flush_out, jump_out, jump_addr_out, e_stall, e_flush, e_jump, e_addr);
      end
      checks++;
      if ({bus_timeout_out, stall_cnt_out, jump_cnt_out} !== {m_timeout, m_stall_cnt, m_jump_cnt}) begin
        errors++;
        $display("FAIL jump_counters cyc%0d: got sc=%0d jc=%0d expected sc=%0d jc=%0d", i,
                 stall_cnt_out, jump_cnt_out, m_stall_cnt, m_jump_cnt);
      end
      if (i == 0) begin
        checks++;
        if (jump_out !== 1'b1 || jump_addr_out !== 32'h100 || flush_out !== 2'b11 || stall_out !== 5'd0) begin
          errors++;
          $display("FAIL jump_issue: got jump=%b addr=%h flush=%b stall=%b expected 1/100/11/0",
                   jump_out, jump_addr_out, flush_out, stall_out);
        end
      end
      if (i == 1) begin
        checks++;
        if (jump_out !== 1'b0 || flush_out !== 2'b11 || stall_out !== 5'd0) begin
          errors++;
          $display("FAIL jump_flush2: got jump=%b flush=%b stall=%b expected 0/11/0", jump_out, flush_out, stall_out);
        end
      end
      if (i == 2) begin
        checks++;
        if (flush_out !== 2'b00 || jump_cnt_out !== jc0 + 32'd1) begin
          errors++;
          $display("FAIL jump_done: got flush=%b jc=%0d expected 00/%0d", flush_out, jump_cnt_out, jc0 + 1);
        end
      end
      post_cycle();
    end
  endtask

  task automatic test_mem_jump();
    for (int i = 0; i < 9; i++) begin
      if (i < 5) apply(0, 0, 1, (i == 2), (i == 2) ? 32'h0000_0200 : 32'h0000_0BAD);
      else apply(0, 0, 0, 0, 32'd0);
      pre_cycle();
      checks++;
      if ({stall_out, flush_out, jump_out, jump_addr_out} !== {e_stall, e_flush, e_jump, e_addr}) begin
        errors++;
        $display("FAIL mem_jump_outputs cyc%0d: got %b/%b/%b/%h expected %b/%b/%b/%h", i,
                 stall_out, flush_out, jump_out, jump_addr_out, e_stall, e_flush, e_jump, e_addr);
      end
      checks++;
      if ({bus_timeout_out, stall_cnt_out, jump_cnt_out} !== {m_timeout, m_stall_cnt, m_jump_cnt}) begin
        errors++;
        $display("FAIL mem_jump_counters cyc%0d: got sc=%0d jc=%0d expected sc=%0d jc=%0d", i,
                 stall_cnt_out, jump_cnt_out, m_stall_cnt, m_jump_cnt);
      end
      if (i < 5) begin
        checks++;
        if (stall_out !== 5'b01111 || jump_out !== 1'b0) begin
          errors++;
          $display("FAIL mem_stall_pattern cyc%0d: got stall=%b jump=%b expected 01111/0", i, stall_out, jump_out);
        end
      end
      if (i == 6) begin
        checks++;
        if (jump_out !== 1'b1 || jump_addr_out !== 32'h200) begin
          errors++;
          $display("FAIL mem_jump_replay: got jump=%b addr=%h expected 1/200", jump_out, jump_addr_out);
        end
      end
      if (i == 7) begin
        checks++;
        if (flush_out !== 2'b11 || jump_out !== 1'b0) begin
          errors++;
          $display("FAIL mem_jump_flush2: got flush=%b jump=%b expected 11/0", flush_out, jump_out);
        end
      end
      post_cycle();
    end
  endtask

  task automatic test_priority();
    for (int i = 0; i < 5; i++) begin
      if (i == 0) apply(1, 1, 1, 1, 32'h0000_0444);
      else apply(0, 0, 0, 0, 32'd0);
      pre_cycle();
      checks++;
      if ({stall_out, flush_out, jump_out, jump_addr_out} !== {e_stall, e_flush, e_jump, e_addr}) begin
        errors++;
        $display("FAIL priority_outputs cyc%0d: got %b/%b/%b/%h expected %b/%b/%b/%h", i,
                 stall_out, flush_out, jump_out, jump_addr_out, e_stall, e_flush, e_jump, e_addr);
      end
      if (i == 0) begin
        checks++;
        if (stall_out !== 5'b01111 || jump_out !== 1'b0 || flush_out !== 2'b00) begin
          errors++;
          $display("FAIL priority_mem_wins: got stall=%b jump=%b flush=%b expected 01111/0/00",
                   stall_out, jump_out, flush_out);
        end
      end
      post_cycle();
    end
  endtask

  task automatic test_timeout();
    do_reset();
    for (int i = 0; i < 257; i++) begin
      apply(0, (i >= 10) ? 1'($urandom_range(0, 1)) : 1'b0, 1, 0, 32'd0);
      pre_cycle();
      checks++;
      if ({stall_out, flush_out, jump_out, jump_addr_out} !== {e_stall, e_flush, e_jump, e_addr}) begin
        errors++;
        $display("FAIL timeout_main_outputs cyc%0d: got %b/%b/%b/%h expected %b/%b/%b/%h", i,
                 stall_out, flush_out, jump_out, jump_addr_out, e_stall, e_flush, e_jump, e_addr);
      end
      checks++;
      if ({bus_timeout_out, stall_cnt_out, jump_cnt_out} !== {m_timeout, m_stall_cnt, m_jump_cnt}) begin
        errors++;
        $display("FAIL timeout_main_state cyc%0d: got to=%b sc=%0d expected to=%b sc=%0d", i,
                 bus_timeout_out, stall_cnt_out, m_timeout, m_stall_cnt);
      end
      if (i < 10) begin
        checks++;
        if ({to_stall, to_flush, to_jump, to_timeout, to_stall_cnt} !==
            {(i < TO_SHORT) ? 5'b01111 : 5'b00000, 2'b00, 1'b0, (i >= TO_SHORT), (i < TO_SHORT) ? 32'(i) : 32'(TO_SHORT)}) begin
          errors++;
          $display("FAIL timeout_short cyc%0d: got stall=%b flush=%b jump=%b to=%b sc=%0d", i,
                   to_stall, to_flush, to_jump, to_timeout, to_stall_cnt);
        end
      end
      post_cycle();
    end
    checks++;
    if (bus_timeout_out !== 1'b1 || to_jump_cnt !== 32'd0 || to_addr !== 32'd0) begin
      errors++;
      $display("FAIL timeout_main_sticky: got to=%b short_jc=%0d short_addr=%h expected 1/0/0",
               bus_timeout_out, to_jump_cnt, to_addr);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      apply(0, 0, 1, (i == 0), 32'h0000_0300);
      pre_cycle();
      checks++;
      if ({stall_out, flush_out, jump_out, jump_addr_out} !== {e_stall, e_flush, e_jump, e_addr}) begin
        errors++;
        $display("FAIL reset_mid_pre cyc%0d: got %b/%b/%b/%h expected %b/%b/%b/%h", i,
                 stall_out, flush_out, jump_out, jump_addr_out, e_stall, e_flush, e_jump, e_addr);
      end
      post_cycle();
    end
    #2;
    reset_n_in = 0;
    model_reset();
    #1;
    checks++;
    if ({stall_out, flush_out, jump_out, jump_addr_out, stall_cnt_out, jump_cnt_out} !== 104'd0) begin
      errors++;
      $display("FAIL reset_mid_immediate: got stall=%b flush=%b jump=%b sc=%0d, expected zeros",
               stall_out, flush_out, jump_out, stall_cnt_out);
    end
    @(posedge clk_in);
    #1;
    reset_n_in = 1;
    apply(0, 0, 0, 0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      pre_cycle();
      checks++;
      if ({stall_out, flush_out, jump_out, jump_addr_out} !== {e_stall, e_flush, e_jump, e_addr}
          || jump_out !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_after cyc%0d: got %b/%b/%b/%h expected %b/%b/%b/%h", i,
                 stall_out, flush_out, jump_out, jump_addr_out, e_stall, e_flush, e_jump, e_addr);
      end
      post_cycle();
    end
  endtask

  task automatic test_random();
    int burst;
    burst = 0;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      logic m;
      if (burst == 0 && $urandom_range(0, 7) == 0) burst = $urandom_range(1, 6);
      m = (burst > 0);
      if (burst > 0) burst = burst - 1;
      apply(($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0), m,
            ($urandom_range(0, 5) == 0), $urandom);
      pre_cycle();
      checks++;
      if ({stall_out, flush_out, jump_out, jump_addr_out} !== {e_stall, e_flush, e_jump, e_addr}) begin
        errors++;
        $display("FAIL random_outputs cyc%0d: got %b/%b/%b/%h expected %b/%b/%b/%h", i,
                 stall_out, flush_out, jump_out, jump_addr_out, e_stall, e_flush, e_jump, e_addr);
      end
      checks++;
      if ({bus_timeout_out, stall_cnt_out, jump_cnt_out} !== {m_timeout, m_stall_cnt, m_jump_cnt}) begin
        errors++;
        $display("FAIL random_counters cyc%0d: got to=%b sc=%0d jc=%0d expected to=%b sc=%0d jc=%0d", i,
                 bus_timeout_out, stall_cnt_out, jump_cnt_out, m_timeout, m_stall_cnt, m_jump_cnt);
      end
      post_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_jump();
    test_mem_jump();
    test_priority();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
